// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch-direction predictor table.
package bp_pkg;

    typedef enum logic {
        BP_LOCAL  = 1'b0,
        BP_GSHARE = 1'b1
    } bp_mode_e;

    localparam logic STATE_INIT = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    // Weakly not-taken: the value just below the taken threshold (0 for 1-bit counters).
    function automatic int ctr_init(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                             input int ctr_bits);
        logic [31:0] max_val;
        max_val = (32'd1 << ctr_bits) - 32'd1;
        if (taken) begin
            return (ctr >= max_val) ? max_val : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational saturating up/down step for one predictor counter.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                taken,
    output logic [CTR_BITS-1:0] ctr_upd
);

    assign ctr_upd = CTR_BITS'(ctr_next(32'(ctr), taken, CTR_BITS));

endmodule

// File: rtl/bp_counter_table.sv
// Branch-direction counter table with local or gshare indexing, a post-reset
// initialisation sweep, and independent predict and update ports.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int       INDEX_BITS = 4,
    parameter int       CTR_BITS   = 2,
    parameter int       HIST_BITS  = 4,
    parameter bp_mode_e MODE       = BP_LOCAL
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic                 pred_req,
    input  logic [31:0]          pred_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [HIST_BITS-1:0] upd_hist
);

    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);

    logic                  state_reg;
    logic [INDEX_BITS-1:0] sweep_reg;
    logic [HIST_BITS-1:0]  ghr_reg;
    logic [HIST_BITS-1:0]  ghr_next;
    logic                  ready_reg;
    logic                  pred_valid_reg;
    logic                  pred_taken_reg;
    logic [HIST_BITS-1:0]  pred_hist_reg;

    logic [CTR_BITS-1:0]   table_mem [DEPTH];

    logic [INDEX_BITS-1:0] pred_base;
    logic [INDEX_BITS-1:0] upd_base;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   upd_ctr;
    logic [CTR_BITS-1:0]   upd_ctr_next;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_addr;
    logic [CTR_BITS-1:0]   wr_data;

    assign pred_base = pred_pc[INDEX_BITS+1:2];
    assign upd_base  = upd_pc[INDEX_BITS+1:2];

    generate
        if (MODE == BP_GSHARE) begin : g_gshare
            // Predict hashes with the live GHR, update with the history captured at predict time.
            assign pred_idx = pred_base ^ INDEX_BITS'(ghr_reg);
            assign upd_idx  = upd_base ^ INDEX_BITS'(upd_hist);
            logic pc_unused;
            assign pc_unused = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                                 upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};
        end else begin : g_local
            assign pred_idx = pred_base;
            assign upd_idx  = upd_base;
            logic pc_unused;
            assign pc_unused = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                                 upd_pc[31:INDEX_BITS+2], upd_pc[1:0], upd_hist};
        end
    endgenerate

    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign ghr_next = upd_taken;
        end else begin : g_hist_shift
            assign ghr_next = {ghr_reg[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    // Asynchronous read on the update side keeps back-to-back updates to one index exact.
    assign upd_ctr = table_mem[upd_idx];

    bp_sat_ctr #(
        .CTR_BITS(CTR_BITS)
    ) u_sat_ctr (
        .ctr    (upd_ctr),
        .taken  (upd_taken),
        .ctr_upd(upd_ctr_next)
    );

    // Single write port shared by the init sweep and the resolved-branch updates.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sweep_reg;
        wr_data = CTR_INIT;
        if (!rst) begin
            if (state_reg == STATE_INIT) begin
                wr_en = 1'b1;
            end else if (upd_valid) begin
                wr_en   = 1'b1;
                wr_addr = upd_idx;
                wr_data = upd_ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= STATE_INIT;
            sweep_reg      <= '0;
            ghr_reg        <= '0;
            ready_reg      <= 1'b0;
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_hist_reg  <= '0;
        end else if (state_reg == STATE_INIT) begin
            pred_valid_reg <= 1'b0;
            sweep_reg      <= sweep_reg + 1'b1;
            if (sweep_reg == LAST_IDX) begin
                state_reg <= STATE_RUN;
                ready_reg <= 1'b1;
            end
        end else begin
            // Reads here see the pre-update counter and pre-shift GHR of the same edge.
            pred_valid_reg <= pred_req;
            if (pred_req) begin
                pred_taken_reg <= table_mem[pred_idx][CTR_BITS-1];
                pred_hist_reg  <= ghr_reg;
            end
            if (upd_valid) begin
                ghr_reg <= ghr_next;
            end
        end
    end

    assign ready      = ready_reg;
    assign pred_valid = pred_valid_reg;
    assign pred_taken = pred_taken_reg;
    assign pred_hist  = pred_hist_reg;

endmodule

// File: tb/tb_bp_counter_table.sv
// Directed and random checks of three predictor configurations against a cycle-level reference model.
module tb_bp_counter_table;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [3:0]  upd_hist = '0;

    logic       ready_l, pv_l, pt_l;
    logic [3:0] ph_l;
    logic       ready_g, pv_g, pt_g;
    logic [3:0] ph_g;
    logic       ready_w, pv_w, pt_w;
    logic [3:0] ph_w;

    always #5 clk = ~clk;

    bp_counter_table #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .MODE(BP_LOCAL)) u_loc (
        .clk(clk), .rst(rst), .ready(ready_l),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv_l), .pred_taken(pt_l), .pred_hist(ph_l),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_hist(upd_hist));

    bp_counter_table #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .MODE(BP_GSHARE)) u_gsh (
        .clk(clk), .rst(rst), .ready(ready_g),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv_g), .pred_taken(pt_g), .pred_hist(ph_g),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_hist(upd_hist));

    bp_counter_table #(.INDEX_BITS(6), .CTR_BITS(3), .HIST_BITS(4), .MODE(BP_LOCAL)) u_wide (
        .clk(clk), .rst(rst), .ready(ready_w),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv_w), .pred_taken(pt_w), .pred_hist(ph_w),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_hist(upd_hist));

    // Reference model: one entry per instance (local 16x2, gshare 16x2, local 64x3).
    int m_depth [3] = '{16, 16, 64};
    int m_bits  [3] = '{2, 2, 3};
    bit m_gsh   [3] = '{1'b0, 1'b1, 1'b0};
    int m_ctr   [3][64];
    int m_ghr   [3];
    int m_cnt   [3];
    bit m_rdy   [3];
    bit e_valid [3];
    bit e_taken [3];
    int e_hist  [3];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    function automatic int idx_of(input int m, input logic [31:0] pc, input int h);
        int b;
        b = int'(pc >> 2) % m_depth[m];
        return m_gsh[m] ? (b ^ h) : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic model_step(input int m);
        int i;
        if (rst) begin
            m_rdy[m]   = 1'b0;
            m_cnt[m]   = 0;
            m_ghr[m]   = 0;
            e_valid[m] = 1'b0;
            for (int k = 0; k < m_depth[m]; k++) m_ctr[m][k] = (1 << (m_bits[m] - 1)) - 1;
        end else if (!m_rdy[m]) begin
            m_cnt[m]++;
            if (m_cnt[m] == m_depth[m]) m_rdy[m] = 1'b1;
            e_valid[m] = 1'b0;
        end else begin
            e_valid[m] = pred_req;
            if (pred_req) begin
                e_taken[m] = m_ctr[m][idx_of(m, pred_pc, m_ghr[m])] >= (1 << (m_bits[m] - 1));
                e_hist[m]  = m_ghr[m];
            end
            if (upd_valid) begin
                i = idx_of(m, upd_pc, int'(upd_hist));
                if (upd_taken && m_ctr[m][i] < (1 << m_bits[m]) - 1) m_ctr[m][i]++;
                else if (!upd_taken && m_ctr[m][i] > 0) m_ctr[m][i]--;
                m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_taken)) & 15;
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] o_rdy, o_v, o_t, o_h;
        for (int m = 0; m < 3; m++) model_step(m);
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < 3; m++) begin
            case (m)
                0: begin o_rdy = 32'(ready_l); o_v = 32'(pv_l); o_t = 32'(pt_l); o_h = 32'(ph_l); end
                1: begin o_rdy = 32'(ready_g); o_v = 32'(pv_g); o_t = 32'(pt_g); o_h = 32'(ph_g); end
                default: begin o_rdy = 32'(ready_w); o_v = 32'(pv_w); o_t = 32'(pt_w); o_h = 32'(ph_w); end
            endcase
            check($sformatf("ready%0d", m), o_rdy, 32'(m_rdy[m]));
            check($sformatf("pred_valid%0d", m), o_v, 32'(e_valid[m]));
            if (e_valid[m]) begin
                check($sformatf("pred_taken%0d", m), o_t, 32'(e_taken[m]));
                check($sformatf("pred_hist%0d", m), o_h, 32'(e_hist[m]));
            end
        end
    endtask

    task automatic drive(input bit pr, input logic [31:0] ppc, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [3:0] uh);
        pred_req  = pr;
        pred_pc   = ppc;
        upd_valid = uv;
        upd_pc    = upc;
        upd_taken = ut;
        upd_hist  = uh;
        cycle();
    endtask

    initial begin
        // Reset state, then a sweep interrupted at cycle 7 with traffic that must be ignored.
        rst = 1'b1;
        drive(1, 32'h8, 1, 32'h8, 1, 4'h0);
        check("reset_ready", 32'(ready_l), 32'd0);
        check("reset_valid", 32'(pv_l), 32'd0);
        check("reset_taken", 32'(pt_l), 32'd0);
        check("reset_hist", 32'(ph_l), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) drive(1, 32'(i * 4), 1, 32'(i * 4), 1, 4'h0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 4'h0);
            check("ready_sweep", 32'(ready_l), (i == 15) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i * 4), 0, 0, 0, 4'h0);
            check("init_pred", 32'(pt_l), 32'd0);
        end

        // Saturation at PC 0x8: predict alongside each taken update sees the pre-update counter.
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h8, 1, 32'h8, 1, 4'h0);
            check("sat_taken", 32'(pt_l), (k == 0) ? 32'd0 : 32'd1);
        end
        drive(0, 0, 1, 32'h8, 0, 4'h0);
        drive(1, 32'h8, 0, 0, 0, 4'h0);
        check("sat_nt1", 32'(pt_l), 32'd1);
        drive(0, 0, 1, 32'h8, 0, 4'h0);
        drive(1, 32'h8, 0, 0, 0, 4'h0);
        check("sat_nt2", 32'(pt_l), 32'd0);

        drive(1, 32'h10, 1, 32'h10, 1, 4'h0);
        check("collide_same", 32'(pt_l), 32'd0);
        drive(1, 32'h10, 0, 0, 0, 4'h0);
        check("collide_next", 32'(pt_l), 32'd1);

        // Fresh reset: both sweep lengths, then gshare history and aliasing.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 0, 0, 0, 4'h0);
            if (i == 15) check("ready_l16", 32'(ready_l), 32'd1);
            if (i == 62) check("ready_w63", 32'(ready_w), 32'd0);
            if (i == 63) check("ready_w64", 32'(ready_w), 32'd1);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'h3C, 1, 4'h0);
        drive(1, 32'h4, 0, 0, 0, 4'h0);
        check("gsh_hist7", 32'(ph_g), 32'h7);
        check("gsh_pred_pre", 32'(pt_g), 32'd0);
        drive(0, 0, 1, 32'h4, 1, 4'h7);
        drive(0, 0, 1, 32'h4, 1, 4'h7);
        drive(1, 32'h24, 0, 0, 0, 4'h0);
        check("gsh_idx6", 32'(pt_g), 32'd1);
        check("gsh_histF", 32'(ph_g), 32'hF);
        drive(1, 32'h38, 0, 0, 0, 4'h0);
        check("gsh_idx1", 32'(pt_g), 32'd0);

        drive(1, 32'h80, 0, 0, 0, 4'h0);
        check("wide_init", 32'(pt_w), 32'd0);
        drive(0, 0, 1, 32'h80, 1, 4'h0);
        drive(1, 32'h80, 0, 0, 0, 4'h0);
        check("wide_trained", 32'(pt_w), 32'd1);

        // Random stream with occasional mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 63)) << 2),
                  1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 63)) << 2),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
